// File: rtl/regfile_mp.sv
// Multi-port register file (2 sync reads, 1 write) with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data / busy updates onto the read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              wr_ok;
  logic              rsv_ok;
  logic [ADDR_W-1:0] rd_addr    [2];
  logic [DATA_W-1:0] rd_data_p0 [2];
  logic              rd_busy_p0 [2];

  // Out-of-range addresses (non power-of-two DEPTH) and the hardwired zero register are inert.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok      = wr_en  && addr_ok(wr_addr);
  assign rsv_ok     = rsv_en && addr_ok(rsv_addr);
  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // Storage: a reservation is ordered after the write so a same-cycle reserve leaves busy set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end

  // Stage p0: read port lookup (with optional forwarding of this cycle's updates)
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_p0[p] = '0;
      rd_busy_p0[p] = 1'b0;
      if (addr_ok(rd_addr[p])) begin
        rd_data_p0[p] = regs[rd_addr[p]];
        rd_busy_p0[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr[p])) begin
          rd_data_p0[p] = wr_data;
          rd_busy_p0[p] = 1'b0;
        end
        if (rsv_ok && (rsv_addr == rd_addr[p])) rd_busy_p0[p] = 1'b1;
`endif
      end
    end
  end

  // Stage p1: registered read outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_busy_a <= 1'b0;
      rd_busy_b <= 1'b0;
    end else begin
      rd_data_a <= rd_data_p0[0];
      rd_data_b <= rd_data_p0[1];
      rd_busy_a <= rd_busy_p0[0];
      rd_busy_b <= rd_busy_p0[1];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp (DEPTH=12, ZERO_REG=1) against an array-based model,
// plus directed scenarios with literal expectations; honours REGFILE_BYPASS_EN.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int DEPTH = 12;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data;
  logic          rd_busy_a, rd_busy_b, wr_en, rsv_en;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_reg  [16];
  logic          m_busy [16];
  logic [DW-1:0] exp_da = '0, exp_db = '0;
  logic          exp_ba = 1'b0, exp_bb = 1'b0;
  logic          chk_en = 1'b0;

  function automatic logic ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (a != 4'd0);
  endfunction

  // What a read of address a must return after the coming edge, given current inputs.
  function automatic void model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                     output logic b);
    d = '0;
    b = 1'b0;
    if (ok(a)) begin
      d = m_reg[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && ok(wr_addr) && wr_addr == a) begin
        d = wr_data;
        b = 1'b0;
      end
      if (rsv_en && ok(rsv_addr) && rsv_addr == a) b = 1'b1;
`endif
    end
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data_a", rd_data_a, exp_da);
      check("rd_data_b", rd_data_b, exp_db);
      check_bit("rd_busy_a", rd_busy_a, exp_ba);
      check_bit("rd_busy_b", rd_busy_b, exp_bb);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    exp_da = '0; exp_db = '0; exp_ba = 1'b0; exp_bb = 1'b0;
  endtask

  task automatic step(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic re,
                      input logic [AW-1:0] rsa);
    logic [DW-1:0] da, db;
    logic          ba, bb;
    rd_addr_a = ra; rd_addr_b = rb;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = rsa;
    model_read(ra, da, ba);
    model_read(rb, db, bb);
    @(posedge clk);
    exp_da = da; exp_db = db; exp_ba = ba; exp_bb = bb;
    if (we && ok(wa)) begin
      m_reg[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (re && ok(rsa)) m_busy[rsa] = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_read(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(ra, rb, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_data_a", rd_data_a, 32'h0);
    check("rst_data_b", rd_data_b, 32'h0);
    check_bit("rst_busy_a", rd_busy_a, 1'b0);
    check_bit("rst_busy_b", rd_busy_b, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
    model_clear();
    #1 rst_n = 1'b0;
    #2;
    check("init_data_a", rd_data_a, 32'h0);
    check_bit("init_busy_a", rd_busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_en = 1'b1;

    // Preload busy r5, then reset between edges
    step(4'd5, 4'd5, 1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5);
    idle_read(4'd5, 4'd5);
    check("pre_r5_data", rd_data_a, 32'hDEADBEEF);
    check_bit("pre_r5_busy", rd_busy_a, 1'b1);
    reset_pulse();
    idle_read(4'd5, 4'd5);
    check("post_rst_r5_data", rd_data_a, 32'h0);
    check_bit("post_rst_r5_busy", rd_busy_b, 1'b0);

    // Basic write then read on both ports
    step(4'd3, 4'd3, 1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0);
    idle_read(4'd3, 4'd3);
    check("r3_port_a", rd_data_a, 32'h12345678);
    check("r3_port_b", rd_data_b, 32'h12345678);

    // Register 0 ignores writes and reservations
    step(4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0);
    idle_read(4'd0, 4'd0);
    check("r0_data", rd_data_a, 32'h0);
    check_bit("r0_busy", rd_busy_b, 1'b0);

    // Scoreboard: reserve r7 at edge 1, write back at edge 3
    step(4'd7, 4'd7, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
`ifdef REGFILE_BYPASS_EN
    check_bit("sb_busy_e1", rd_busy_a, 1'b1);
`else
    check_bit("sb_busy_e1", rd_busy_a, 1'b0);
`endif
    idle_read(4'd7, 4'd7);
    check_bit("sb_busy_e2", rd_busy_a, 1'b1);
    step(4'd7, 4'd7, 1'b1, 4'd7, 32'hA5, 1'b0, 4'd0);
`ifdef REGFILE_BYPASS_EN
    check_bit("sb_busy_e3", rd_busy_a, 1'b0);
    check("sb_data_e3", rd_data_a, 32'hA5);
`else
    check_bit("sb_busy_e3", rd_busy_a, 1'b1);
    check("sb_data_e3", rd_data_a, 32'h0);
`endif
    idle_read(4'd7, 4'd7);
    check_bit("sb_busy_e4", rd_busy_b, 1'b0);
    check("sb_data_e4", rd_data_b, 32'hA5);

    // Same-cycle reserve + write + read of r2
    step(4'd2, 4'd2, 1'b1, 4'd2, 32'h11, 1'b0, 4'd0);
    idle_read(4'd2, 4'd2);
    step(4'd2, 4'd2, 1'b1, 4'd2, 32'h55, 1'b1, 4'd2);
`ifdef REGFILE_BYPASS_EN
    check("sim_data", rd_data_a, 32'h55);
    check_bit("sim_busy", rd_busy_a, 1'b1);
`else
    check("sim_data", rd_data_a, 32'h11);
    check_bit("sim_busy", rd_busy_a, 1'b0);
`endif
    idle_read(4'd2, 4'd2);
    check("sim_next_data", rd_data_b, 32'h55);
    check_bit("sim_next_busy", rd_busy_b, 1'b1);

    // Out of range address 13 with DEPTH=12
    step(4'd13, 4'd13, 1'b1, 4'd13, 32'hCAFEF00D, 1'b1, 4'd13);
    idle_read(4'd13, 4'd13);
    check("oor_data", rd_data_a, 32'h0);
    check_bit("oor_busy", rd_busy_a, 1'b0);
    idle_read(4'd3, 4'd1);
    check("oor_r3_kept", rd_data_a, 32'h12345678);
    check("oor_r1_clean", rd_data_b, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] wd;
      r  = $urandom;
      wd = $urandom;
      step(r[3:0], r[7:4], r[8], r[15:12], wd, r[9] & r[10], r[19:16]);
      if (i == 700) reset_pulse();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
